// File: rtl/tiles_pkg.sv
// Shared constants and FSM state type for the frame-commit scheduler.
package tiles_pkg;

   localparam int unsigned NCON_DEF  = 4;
   localparam int unsigned DEPTH_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO holding {consumer index, data} entries; a push into a full
// FIFO is accepted only if a pop frees a slot in the same cycle.
module commit_fifo #(
   parameter int unsigned W     = 34,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          res,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic          drop,
   output logic [CW-1:0] cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & ~push_ok;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/apb_frame_commit.sv
// Queues APB register writes and releases them to the consumer registers as
// one back-to-back burst per animate frame pulse.
module apb_frame_commit
   import tiles_pkg::*;
#(
   parameter int unsigned NCON  = NCON_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            res,
   input  logic            write_en0,
   input  logic [NCON-1:0] right_addr,
   input  logic [31:0]     pwdata,
   input  logic            animate,
   output logic [31:0]     cmt_data,
   output logic [NCON-1:0] cmt_load,
   output logic            busy,
   output logic            ovf,
   output logic [CW-1:0]   fifo_cnt
);

   localparam int unsigned IW = (NCON > 1) ? $clog2(NCON) : 1;

   state_t          state;
   state_t          state_d;
   logic [CW-1:0]   remain;
   logic [CW-1:0]   remain_d;
   logic [IW-1:0]   idx;
   logic            push;
   logic            pop;
   logic [IW+31:0]  head;
   logic [IW-1:0]   head_idx;
   logic [31:0]     head_data;
   logic            full;
   logic            empty;
   logic            drop;
   logic [31:0]     data_d;
   logic [NCON-1:0] load_d;

   assign push = write_en0 & (|right_addr);

   // Lowest set bit wins when several consumer selects match.
   always_comb begin
      idx = '0;
      for (int unsigned i = NCON; i > 0; i--) begin
         if (right_addr[i-1]) begin
            idx = IW'(i - 1);
         end
      end
   end

   commit_fifo #(
      .W     (IW + 32),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (push),
      .din   ({idx, pwdata}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .drop  (drop),
      .cnt   (fifo_cnt)
   );

   assign head_idx  = head[IW+31:32];
   assign head_data = head[31:0];

   // remain snapshots occupancy at the frame pulse, so words queued during
   // the drain wait for the next frame.
   always_comb begin
      state_d  = state;
      remain_d = remain;
      pop      = 1'b0;
      load_d   = '0;
      data_d   = cmt_data;
      unique case (state)
         IDLE: begin
            if (animate && !empty) begin
               state_d  = DRAIN;
               remain_d = fifo_cnt;
            end
         end
         DRAIN: begin
            pop              = 1'b1;
            load_d[head_idx] = 1'b1;
            data_d           = head_data;
            remain_d         = remain - CW'(1);
            if (remain == CW'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state    <= IDLE;
         remain   <= '0;
         cmt_data <= '0;
         cmt_load <= '0;
         busy     <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_d;
         remain   <= remain_d;
         cmt_data <= data_d;
         cmt_load <= load_d;
         busy     <= (state == DRAIN);
         ovf      <= ovf | drop;
      end
   end

   logic unused_full;
   assign unused_full = full;

endmodule
